// File: rtl/seven_seg_driver.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_driver
// Brief    : 4-digit common-anode multiplexed hex display driver with
//            frame-synchronous value update and leading-zero blanking.
// Revision : 1.0
// ============================================================================
module seven_seg_driver #(
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int                 C_CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(REFRESH_DIV - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

  logic [C_CNT_W-1:0] r_cnt;
  logic [1:0]         r_idx;
  logic [15:0]        r_shadow_val;
  logic [3:0]         r_shadow_dp;
  logic [15:0]        r_disp_val;
  logic [3:0]         r_disp_dp;
  logic               r_pending;
  logic [3:0]         r_an;
  logic [6:0]         r_seg;
  logic               r_dp;

  logic               w_tick;
  logic               w_frame;
  logic [3:0]         w_nib;
  logic               w_blank;
  logic [6:0]         w_seg_dec;
  logic [3:0]         w_an_sel;

  assign w_tick  = (r_cnt == C_CNT_MAX);
  assign w_frame = w_tick && (r_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + C_CNT_ONE;
    end
  end

  // A load coinciding with the boundary bypasses the shadow so it is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow_val <= 16'h0;
      r_shadow_dp  <= 4'h0;
      r_disp_val   <= 16'h0;
      r_disp_dp    <= 4'h0;
      r_pending    <= 1'b0;
    end else if (w_frame) begin
      if (load) begin
        r_disp_val <= value;
        r_disp_dp  <= dp_en;
      end else if (r_pending) begin
        r_disp_val <= r_shadow_val;
        r_disp_dp  <= r_shadow_dp;
      end
      r_pending <= 1'b0;
    end else if (load) begin
      r_shadow_val <= value;
      r_shadow_dp  <= dp_en;
      r_pending    <= 1'b1;
    end
  end

  always_comb begin
    w_nib    = r_disp_val[3:0];
    w_an_sel = 4'b1110;
    case (r_idx)
      2'd0: begin w_nib = r_disp_val[3:0];   w_an_sel = 4'b1110; end
      2'd1: begin w_nib = r_disp_val[7:4];   w_an_sel = 4'b1101; end
      2'd2: begin w_nib = r_disp_val[11:8];  w_an_sel = 4'b1011; end
      default: begin w_nib = r_disp_val[15:12]; w_an_sel = 4'b0111; end
    endcase
  end

  if (BLANK_LEADING != 0) begin : g_blank
    always_comb begin
      w_blank = 1'b0;
      case (r_idx)
        2'd1:    w_blank = (r_disp_val[15:4]  == 12'h0);
        2'd2:    w_blank = (r_disp_val[15:8]  == 8'h0);
        2'd3:    w_blank = (r_disp_val[15:12] == 4'h0);
        default: w_blank = 1'b0;
      endcase
    end
  end else begin : g_no_blank
    assign w_blank = 1'b0;
  end

  always_comb begin
    w_seg_dec = 7'b1111111;
    case (w_nib)
      4'h0: w_seg_dec = 7'b1000000;
      4'h1: w_seg_dec = 7'b1111001;
      4'h2: w_seg_dec = 7'b0100100;
      4'h3: w_seg_dec = 7'b0110000;
      4'h4: w_seg_dec = 7'b0011001;
      4'h5: w_seg_dec = 7'b0010010;
      4'h6: w_seg_dec = 7'b0000010;
      4'h7: w_seg_dec = 7'b1111000;
      4'h8: w_seg_dec = 7'b0000000;
      4'h9: w_seg_dec = 7'b0010000;
      4'hA: w_seg_dec = 7'b0001000;
      4'hB: w_seg_dec = 7'b0000011;
      4'hC: w_seg_dec = 7'b1000110;
      4'hD: w_seg_dec = 7'b0100001;
      4'hE: w_seg_dec = 7'b0000110;
      default: w_seg_dec = 7'b0001110;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else if (w_blank) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_sel;
      r_seg <= w_seg_dec;
      r_dp  <= ~r_disp_dp[r_idx];
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_driver
// Brief    : Self-checking bench for seven_seg_driver, blanking on and off.
// Revision : 1.0
// ============================================================================
module tb_seven_seg_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;
  localparam logic [11:0] RST_OUT = {4'b1111, 7'b1111111, 1'b1};
  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_en = 4'h0;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;

  seven_seg_driver #(.REFRESH_DIV(DIV), .BLANK_LEADING(1)) u_dut_a (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_en(dp_en),
    .an(an_a), .seg(seg_a), .dp(dp_a));

  seven_seg_driver #(.REFRESH_DIV(DIV), .BLANK_LEADING(0)) u_dut_b (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_en(dp_en),
    .an(an_b), .seg(seg_b), .dp(dp_b));

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          t = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_val = 16'h0, m_sh = 16'h0;
  logic [3:0]  m_dp = 4'h0, m_shdp = 4'h0;
  bit          m_pend = 1'b0;
  logic [11:0] m_exp_a = RST_OUT, m_exp_b = RST_OUT;

  // What digit idx of value v looks like on the pins, packed {an,seg,dp}.
  function automatic logic [11:0] shown(int idx, logic [15:0] v, logic [3:0] d, bit blank_en);
    logic [15:0] upper;
    logic [3:0]  an_v;
    upper = v >> (4 * idx);
    if (blank_en && idx > 0 && upper == 16'h0) return RST_OUT;
    an_v = 4'hF;
    an_v[idx] = 1'b0;
    return {an_v, SEG_TBL[upper[3:0]], ~d[idx]};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got {an,seg,dp}=%b required %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("blank_on", {an_a, seg_a, dp_a}, m_exp_a);
      chk("blank_off", {an_b, seg_b, dp_b}, m_exp_b);
    end
  end

  task automatic step(input bit r, input bit l, input logic [15:0] v, input logic [3:0] d);
    int idx;
    reset = r; load = l; value = v; dp_en = d;
    @(posedge clk);
    #1;
    if (r) begin
      t = 0; m_val = 16'h0; m_dp = 4'h0; m_sh = 16'h0; m_shdp = 4'h0; m_pend = 1'b0;
      m_exp_a = RST_OUT; m_exp_b = RST_OUT;
    end else begin
      idx = (t / DIV) % 4;
      m_exp_a = shown(idx, m_val, m_dp, 1'b1);
      m_exp_b = shown(idx, m_val, m_dp, 1'b0);
      if (t % FRAME == FRAME - 1) begin
        if (l) begin m_val = v; m_dp = d; end
        else if (m_pend) begin m_val = m_sh; m_dp = m_shdp; end
        m_pend = 1'b0;
      end else if (l) begin
        m_sh = v; m_shdp = d; m_pend = 1'b1;
      end
      t++;
    end
    m_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic sync_to(input int p);
    for (int g = 0; g < FRAME && (t % FRAME) != p; g++) idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] rv;
    // Reset and release
    repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0);
    chk("lit_reset", {an_a, seg_a, dp_a}, RST_OUT);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    chk("lit_release", {an_a, seg_a, dp_a}, {4'b1110, 7'b1000000, 1'b1});

    // Mid-frame load of 12AF with dp on digit 2
    sync_to(6);
    step(1'b0, 1'b1, 16'h12AF, 4'b0100);
    sync_to(0);
    idle(1);
    chk("lit_12af_d0", {an_a, seg_a, dp_a}, {4'b1110, 7'b0001110, 1'b1});
    idle(4);
    chk("lit_12af_d1", {an_a, seg_a, dp_a}, {4'b1101, 7'b0001000, 1'b1});
    idle(4);
    chk("lit_12af_d2", {an_a, seg_a, dp_a}, {4'b1011, 7'b0100100, 1'b0});
    idle(4);
    chk("lit_12af_d3", {an_a, seg_a, dp_a}, {4'b0111, 7'b1111001, 1'b1});

    // Two loads in one frame: last wins
    sync_to(2);
    step(1'b0, 1'b1, 16'h0001, 4'h0);
    idle(2);
    step(1'b0, 1'b1, 16'h0003, 4'h0);
    sync_to(0);
    idle(1);
    chk("lit_last_wins", {an_a, seg_a, dp_a}, {4'b1110, 7'b0110000, 1'b1});
    idle(4);
    chk("lit_blank_d1", {an_a, seg_a, dp_a}, RST_OUT);

    // Load exactly on the frame boundary
    sync_to(FRAME - 1);
    step(1'b0, 1'b1, 16'h00F0, 4'h0);
    idle(1);
    chk("lit_bnd_a_d0", {an_a, seg_a, dp_a}, {4'b1110, 7'b1000000, 1'b1});
    chk("lit_bnd_b_d0", {an_b, seg_b, dp_b}, {4'b1110, 7'b1000000, 1'b1});
    idle(4);
    chk("lit_bnd_a_d1", {an_a, seg_a, dp_a}, {4'b1101, 7'b0001110, 1'b1});
    chk("lit_bnd_b_d1", {an_b, seg_b, dp_b}, {4'b1101, 7'b0001110, 1'b1});
    idle(4);
    chk("lit_bnd_a_d2", {an_a, seg_a, dp_a}, RST_OUT);
    chk("lit_bnd_b_d2", {an_b, seg_b, dp_b}, {4'b1011, 7'b1000000, 1'b1});
    idle(4);
    chk("lit_bnd_b_d3", {an_b, seg_b, dp_b}, {4'b0111, 7'b1000000, 1'b1});

    // Reset while a value is pending discards it
    sync_to(4);
    step(1'b0, 1'b1, 16'hBEEF, 4'hF);
    idle(2);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    chk("lit_mid_reset", {an_a, seg_a, dp_a}, RST_OUT);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    chk("lit_post_reset", {an_a, seg_a, dp_a}, {4'b1110, 7'b1000000, 1'b1});
    idle(3 * FRAME + 20);
    chk("lit_no_beef", {an_b, seg_b, dp_b}, shown(((t - 1) / DIV) % 4, 16'h0, 4'h0, 1'b0));

    // Randomized traffic, including boundary loads and stray resets
    for (int i = 0; i < 1200; i++) begin
      rv = 16'($urandom);
      rv = rv >> (4 * $urandom_range(0, 3));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, rv, 4'($urandom));
    end
    step(1'b0, 1'b0, 16'h0, 4'h0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
